// File: rtl/sbox_layer_ctrl.sv
// Nibble-serial PRESENT S-box layer: one shared 4-bit S-box walks the state
// register LSB-first, one nibble per clock, then holds the result until it is consumed.

module sbox_combinational (
    input  logic [3:0] x_i,
    output logic [3:0] y_o
);
    always_comb begin
        y_o = 4'h0;
        unique case (x_i)
            4'h0: y_o = 4'hC;
            4'h1: y_o = 4'h5;
            4'h2: y_o = 4'h6;
            4'h3: y_o = 4'hB;
            4'h4: y_o = 4'h9;
            4'h5: y_o = 4'h0;
            4'h6: y_o = 4'hA;
            4'h7: y_o = 4'hD;
            4'h8: y_o = 4'h3;
            4'h9: y_o = 4'hE;
            4'hA: y_o = 4'hF;
            4'hB: y_o = 4'h8;
            4'hC: y_o = 4'h4;
            4'hD: y_o = 4'h7;
            4'hE: y_o = 4'h1;
            4'hF: y_o = 4'h2;
            default: y_o = 4'h0;
        endcase
    end
endmodule

module sbox_layer_ctrl #(
    parameter int NIB = 16,
    localparam int W  = 4 * NIB,
    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  din,
    input  logic          out_ready,
    output logic          in_ready,
    output logic          busy,
    output logic [W-1:0]  dout,
    output logic          dout_valid,
    output logic [IW-1:0] idx
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  data_q, data_d;
    logic [IW-1:0] idx_q, idx_d;

    logic [3:0]    sbox_in, sbox_out;
    logic [W-1:0]  subst_data;

    assign sbox_in = data_q[idx_q*4 +: 4];

    sbox_combinational u_sbox (
        .x_i (sbox_in),
        .y_o (sbox_out)
    );

    // Only the nibble addressed by idx_q takes the substituted value.
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            assign subst_data[gi*4 +: 4] = (idx_q == IW'(gi)) ? sbox_out : data_q[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    data_d  = din;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                data_d = subst_data;
                if (idx_q == IW'(NIB - 1)) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign dout_valid = (state_q == DONE);
    assign dout       = data_q;
    assign idx        = idx_q;
endmodule

// File: tb/tb_sbox_layer_ctrl.sv
// Scoreboard bench for sbox_layer_ctrl: expected results are queued at start,
// and a monitor compares them at each output handshake.

module tb_sbox_layer_ctrl;
    localparam int NIB = 16;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst_n, start, out_ready;
    logic [W-1:0] din;
    logic         in_ready, busy, dout_valid;
    logic [W-1:0] dout;
    logic [3:0]   idx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [W-1:0] exp_q[$];

    sbox_layer_ctrl #(.NIB(NIB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din),
        .out_ready(out_ready), .in_ready(in_ready), .busy(busy),
        .dout(dout), .dout_valid(dout_valid), .idx(idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] model(input logic [W-1:0] d);
        logic [3:0] tbl [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                 4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
        logic [W-1:0] r;
        r = '0;
        for (int n = 0; n < NIB; n++) r[4*n +: 4] = tbl[d[4*n +: 4]];
        return r;
    endfunction

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: compare at every accepted output.
    always @(negedge clk) begin
        if (rst_n && dout_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected none", dout);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("dout", dout, e);
                $display("txn dout=%h expected=%h", dout, e);
            end
        end
    end

    task automatic start_block(input logic [W-1:0] d);
        check("in_ready_before_start", W'(in_ready), W'(1));
        start = 1'b1;
        din   = d;
        @(posedge clk); #1;
        start = 1'b0;
        din   = rnd64();
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!dout_valid && n < 40) begin
            if ($urandom_range(0, 1) == 1) out_ready = $urandom_range(0, 1);
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b0;
        if (!dout_valid) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout: got no dout_valid after %0d cycles expected 16", n);
        end
    endtask

    task automatic release_block(input int stall);
        out_ready = 1'b0;
        repeat (stall) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_block(input logic [W-1:0] d, input logic [W-1:0] e, input int stall);
        int n;
        exp_q.push_back(e);
        start_block(d);
        wait_valid(n);
        check("latency", W'(n), W'(16));
        release_block(stall);
    endtask

    initial begin
        int n, t1, t2;
        logic [W-1:0] held;
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_busy", W'(busy), W'(0));
        check("rst_valid", W'(dout_valid), W'(0));
        check("rst_dout", dout, '0);
        check("rst_idx", W'(idx), W'(0));
        rst_n = 1'b1;

        run_block('0, 64'hCCCCCCCCCCCCCCCC, 0);
        run_block(64'h0123456789ABCDEF, 64'hC56B90AD3EF84712, 2);
        run_block(64'hFFFFFFFFFFFFFFFF, 64'h2222222222222222, 0);

        // Partial progress after four BUSY edges.
        exp_q.push_back(64'hCCCCCCCCCCCCCCCC);
        start_block('0);
        repeat (4) @(posedge clk);
        #1;
        check("progress_dout", dout, 64'h000000000000CCCC);
        check("progress_idx", W'(idx), W'(4));
        wait_valid(n);
        release_block(0);

        // Backpressure with start pulses in DONE.
        held = rnd64();
        exp_q.push_back(model(held));
        start_block(held);
        wait_valid(n);
        check("bp_latency", W'(n), W'(16));
        held = dout;
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            din   = rnd64();
            @(posedge clk); #1;
            check("bp_valid", W'(dout_valid), W'(1));
            check("bp_dout_stable", dout, held);
        end
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        out_ready = 1'b0;
        check("bp_idle", W'(in_ready), W'(1));
        check("bp_dout_kept", dout, held);
        @(posedge clk); #1;
        check("bp_no_restart", W'(busy), W'(0));

        // Reset while BUSY at idx 7.
        start_block(rnd64());
        repeat (7) @(posedge clk);
        #1;
        check("mid_idx", W'(idx), W'(7));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_rst_busy", W'(busy), W'(0));
        check("mid_rst_idle", W'(in_ready), W'(1));
        check("mid_rst_dout", dout, '0);
        check("mid_rst_idx", W'(idx), W'(0));
        run_block(64'h0123456789ABCDEF, 64'hC56B90AD3EF84712, 1);

        // Back-to-back throughput.
        held = rnd64();
        exp_q.push_back(model(held));
        start_block(held);
        wait_valid(n);
        t1 = cyc;
        release_block(0);
        held = rnd64();
        exp_q.push_back(model(held));
        start_block(held);
        wait_valid(n);
        t2 = cyc;
        check("b2b_spacing", W'(t2 - t1), W'(18));
        release_block(0);

        for (int i = 0; i < 20; i++) begin
            held = rnd64();
            run_block(held, model(held), $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", W'(exp_q.size()), W'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
